ysyx_22050854_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_22050854_mem_arbiter
// PURPOSE
//  Shares the single memory port between the instruction-fetch path (IF) and the load/store path (LS) of the ysyx_22050854 core.
//  Round-robin arbitration, one outstanding transaction at a time.
//  Valid/ready request handshake on every side, and a response pulse routed back to the granted requester.
//  A wait-cycle watchdog turns a lost memory response into an error response, so the core can never hang.
// PARAMETERS
//  ADDR_W   32   address width (matches pc width)
//  DATA_W   64   data width (matches register width); DATA_W/8 byte-mask bits
//  TIMEOUT  255  max cycles spent in WAIT before a forced error response (>=1)
// PORTS
//  clk            in   1         core clock, rising edge
//  rst            in   1         asynchronous, active-high reset
//  if_req_valid   in   1         IF read request
//  if_req_ready   out  1         IF request accepted this cycle
//  if_addr        in   ADDR_W    IF read address
//  if_resp_valid  out  1         1-cycle pulse: if_rdata valid
//  if_rdata       out  DATA_W    IF read data
//  ls_req_valid   in   1         LS request
//  ls_req_ready   out  1         LS request accepted this cycle
//  ls_addr        in   ADDR_W    LS address
//  ls_wen         in   1         1 = write, 0 = read
//  ls_wdata       in   DATA_W    LS write data
//  ls_wmask       in   DATA_W/8  LS byte write mask
//  ls_resp_valid  out  1         1-cycle pulse: read data / write ack
//  ls_rdata       out  DATA_W    LS read data
//  mem_req_valid  out  1         request to memory
//  mem_req_ready  in   1         memory accepts request
//  mem_addr       out  ADDR_W    registered address
//  mem_wen        out  1         registered write enable (0 for IF)
//  mem_wdata      out  DATA_W    registered write data (0 for IF)
//  mem_wmask      out  DATA_W/8  registered mask (0 for IF)
//  mem_resp_valid in   1         memory response strobe
//  mem_rdata      in   DATA_W    memory read data
//  timeout_err    out  1         1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - state=IDLE; all outputs 0; wait counter 0.
//    - last_grant=LS, so IF wins the first conflict.
//    - An in-flight transaction is dropped; no response is issued for it.
//  - IDLE:
//    - *_req_ready is combinational, asserted only in IDLE for the selected requester.
//    - One requester valid -> it is granted.
//    - Both valid -> grant the one that is not last_grant.
//    - On grant: latch owner, addr/wen/wdata/wmask into mem_* regs; update last_grant; go to REQ next cycle.
//  - REQ:
//    - mem_req_valid=1 with stable mem_* until mem_req_ready=1, then go to WAIT.
//    - mem_resp_valid in REQ is ignored.
//  - WAIT:
//    - Wait counter increments every cycle.
//    - On mem_resp_valid: register mem_rdata into the owner's *_rdata and pulse the owner's *_resp_valid the next cycle; go to IDLE.
//    - Counter reaches TIMEOUT without a response: pulse the owner's *_resp_valid with *_rdata=0 and timeout_err=1; go to IDLE; counter cleared.
//  - Writes also return a resp pulse (ack); LS rdata then equals mem_rdata.
//  - The non-owner's resp_valid stays 0; its rdata holds its previous value.
//  - Stray mem_resp_valid in IDLE is ignored.
//  - The response cycle coincides with IDLE, so a new grant can be made in the same cycle the previous response pulses.
//  - Latency: minimum 3 cycles from acceptance to resp pulse (ready in REQ, resp on first WAIT cycle).
//  - Requesters must hold addr/data only until *_req_ready.
// TESTING
//  - Reset: assert rst mid-WAIT -> all outputs 0 in the same cycle; no resp pulse after release.
//  - Single IF read, addr=0x80000000, mem ready at once, resp rdata=0x13 -> if_resp_valid=1 at cycle 3, if_rdata=0x13.
//  - Conflict after reset: both valid -> IF granted first, then LS; with both held valid, grants alternate IF, LS, IF.
//  - LS write, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready delayed 4 cycles -> mem_* stable throughout; ls_resp_valid pulses once.
//  - Timeout, TIMEOUT=4, no mem_resp_valid -> exactly 4 WAIT cycles, then owner resp_valid=1, rdata=0, timeout_err=1 for one cycle; back in IDLE.
//  - Stray mem_resp_valid in IDLE and in REQ -> no resp pulse; state unchanged.

Source files
------------

// File: rtl/ysyx_22050854_mem_arbiter.sv
// ysyx_22050854_mem_arbiter
//   Shares the single memory port between instruction fetch (IF) and load/store (LS).
//   Round-robin arbitration with one outstanding transaction at a time. A watchdog
//   in WAIT turns a lost memory response into an error response so the core never hangs.
//
// Ports
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   if_req_valid/ready, if_addr  IF read request handshake
//   if_resp_valid, if_rdata      1-cycle IF response pulse and registered read data
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask   LS read/write request handshake
//   ls_resp_valid, ls_rdata      1-cycle LS response pulse (read data or write ack)
//   mem_req_valid/ready, mem_*   registered request towards memory
//   mem_resp_valid, mem_rdata    memory response strobe and data
//   timeout_err                  1-cycle pulse when the watchdog forces a response
module ysyx_22050854_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err
);

    // Counter only ever holds 0..TIMEOUT-1.
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic                owner_ls_q;
    logic                last_grant_ls_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_wen_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wmask_q;
    logic                if_resp_valid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                ls_resp_valid_q;
    logic [DATA_W-1:0]   ls_rdata_q;
    logic                timeout_err_q;

    logic grant_if;
    logic grant_ls;
    logic timeout_hit;

    // On a conflict the requester that was not granted last time wins.
    always_comb begin
        grant_if    = if_req_valid && (!ls_req_valid || last_grant_ls_q);
        grant_ls    = ls_req_valid && (!if_req_valid || !last_grant_ls_q);
        timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
        // Gated by rst so every output reads 0 while reset is held.
        if_req_ready = !rst && (state_q == StIdle) && grant_if;
        ls_req_ready = !rst && (state_q == StIdle) && grant_ls;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            owner_ls_q      <= 1'b0;
            last_grant_ls_q <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            if_resp_valid_q <= 1'b0;
            if_rdata_q      <= '0;
            ls_resp_valid_q <= 1'b0;
            ls_rdata_q      <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            timeout_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_if) begin
                        owner_ls_q      <= 1'b0;
                        last_grant_ls_q <= 1'b0;
                        mem_addr_q      <= if_addr;
                        mem_wen_q       <= 1'b0;
                        mem_wdata_q     <= '0;
                        mem_wmask_q     <= '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= StReq;
                    end else if (grant_ls) begin
                        owner_ls_q      <= 1'b1;
                        last_grant_ls_q <= 1'b1;
                        mem_addr_q      <= ls_addr;
                        mem_wen_q       <= ls_wen;
                        mem_wdata_q     <= ls_wdata;
                        mem_wmask_q     <= ls_wmask;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= StReq;
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= StWait;
                    end
                end
                StWait: begin
                    // A real response wins over a watchdog expiry in the same cycle.
                    if (mem_resp_valid || timeout_hit) begin
                        if (owner_ls_q) begin
                            ls_resp_valid_q <= 1'b1;
                            ls_rdata_q      <= mem_resp_valid ? mem_rdata : '0;
                        end else begin
                            if_resp_valid_q <= 1'b1;
                            if_rdata_q      <= mem_resp_valid ? mem_rdata : '0;
                        end
                        timeout_err_q <= !mem_resp_valid;
                        cnt_q         <= '0;
                        state_q       <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign if_resp_valid = if_resp_valid_q;
    assign if_rdata      = if_rdata_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_rdata      = ls_rdata_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_ysyx_22050854_mem_arbiter.sv
// tb_ysyx_22050854_mem_arbiter
//   Self-checking bench for the IF/LS memory arbiter. A behavioural memory answers requests
//   with programmable delays; expected responses are queued when a request is accepted and
//   compared by a monitor when the arbiter pulses a response.
module tb_ysyx_22050854_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_resp_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [7:0]    ls_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;
    logic          timeout_err;

    ysyx_22050854_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_ls;
        logic [DW-1:0] rdata;
        logic          tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Memory model knobs.
    int   req_delay  = 0;
    int   resp_delay = 0;
    logic resp_en    = 1'b1;
    logic stray_en   = 1'b0;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 64'h13;
        return {a ^ 32'h5A5A_5A5A, a};
    endfunction

    // Behavioural memory: accepts after req_delay REQ cycles, answers after resp_delay WAIT cycles.
    initial begin : memory
        int            phase;
        int            wcnt;
        logic [AW-1:0] cap_addr;
        logic          cap_wen;
        logic [DW-1:0] cap_wdata;
        logic [7:0]    cap_wmask;
        phase = 0; wcnt = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        cap_addr = '0; cap_wen = 1'b0; cap_wdata = '0; cap_wmask = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (rst) begin
                phase = 0; wcnt = 0;
            end else if (phase == 0) begin
                if (stray_en) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = 64'hBAD;
                end
                if (mem_req_valid) begin
                    if (wcnt == 0) begin
                        cap_addr = mem_addr; cap_wen = mem_wen;
                        cap_wdata = mem_wdata; cap_wmask = mem_wmask;
                    end else begin
                        n_cmp++;
                        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !==
                            {cap_addr, cap_wen, cap_wdata, cap_wmask}) begin
                            n_fail++;
                            $display("FAIL mem_stable: got %h/%b/%h/%h want %h/%b/%h/%h",
                                     mem_addr, mem_wen, mem_wdata, mem_wmask,
                                     cap_addr, cap_wen, cap_wdata, cap_wmask);
                        end
                    end
                    if (wcnt == req_delay) begin
                        mem_req_ready = 1'b1; phase = 1; wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                if (!resp_en) begin
                    phase = 0; wcnt = 0;
                end else if (wcnt == resp_delay) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = mem_model(cap_addr);
                    phase = 0; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every pulse and checks rdata holding.
    initial begin : monitor
        logic [DW-1:0] prev_if;
        logic [DW-1:0] prev_ls;
        exp_t          e;
        prev_if = '0; prev_ls = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_if = '0; prev_ls = '0;
            end else begin
                if (if_resp_valid || ls_resp_valid) begin
                    n_cmp++;
                    if (sb_q.size() == 0 || (if_resp_valid && ls_resp_valid)) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: if=%b ls=%b queued=%0d",
                                 if_resp_valid, ls_resp_valid, sb_q.size());
                    end else begin
                        e = sb_q.pop_front();
                        if (ls_resp_valid !== e.is_ls ||
                            (e.is_ls ? ls_rdata : if_rdata) !== e.rdata ||
                            timeout_err !== e.tmo) begin
                            n_fail++;
                            $display("FAIL resp_data: got ls=%b rdata=%h tmo=%b want ls=%b rdata=%h tmo=%b",
                                     ls_resp_valid, e.is_ls ? ls_rdata : if_rdata, timeout_err,
                                     e.is_ls, e.rdata, e.tmo);
                        end
                    end
                end else if (timeout_err !== 1'b0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL timeout_err_alone: got %b want 0", timeout_err);
                end
                n_cmp++;
                if ((!if_resp_valid && if_rdata !== prev_if) ||
                    (!ls_resp_valid && ls_rdata !== prev_ls)) begin
                    n_fail++;
                    $display("FAIL rdata_hold: got if=%h ls=%h want if=%h ls=%h",
                             if_rdata, ls_rdata, prev_if, prev_ls);
                end
                prev_if = if_rdata;
                prev_ls = ls_rdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    // Drives one request until accepted; returns 1 ns after the accepting edge.
    task automatic issue(input logic is_ls, input logic [AW-1:0] addr, input logic wen,
                         input logic [DW-1:0] wdata, input logic [7:0] wmask,
                         input logic push, input logic tmo);
        logic acc;
        int   n;
        acc = 1'b0; n = 0;
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_addr = addr; ls_wen = wen;
            ls_wdata = wdata; ls_wmask = wmask;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        while (!acc && n < 50) begin
            @(negedge clk);
            if (is_ls ? ls_req_ready : if_req_ready) begin
                acc = 1'b1;
                if (push) sb_q.push_back('{is_ls, tmo ? '0 : mem_model(addr), tmo});
            end
            tick();
            n++;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL issue_accept: got no ready want ready within 50 cycles");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            tick(); n++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d responses pending want 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        #1;
        n_cmp++;
        if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid,
             mem_wen, timeout_err, if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero output want all 0");
        end
        tick(); tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        rst = 1'b0;
        tick();
        // Reset in the middle of WAIT: transaction is dropped without a response.
        resp_en = 1'b0;
        issue(1'b0, 32'h8000_0040, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid,
             mem_wen, timeout_err, if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            n_fail++;
            $display("FAIL reset_midwait: got mem_addr=%h mem_req_valid=%b want all 0",
                     mem_addr, mem_req_valid);
        end
        tick();
        rst = 1'b0;
        resp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (if_resp_valid !== 1'b0 || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_resp: got if_resp_valid=%b want 0", if_resp_valid);
            end
        end
        tick();
    endtask

    task automatic test_single_read();
        req_delay = 0; resp_delay = 0;
        issue(1'b0, 32'h8000_0000, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
                    {1'b1, 32'h8000_0000, 1'b0, 64'h0, 8'h0}) begin
                    n_fail++;
                    $display("FAIL if_mem_req: got v=%b addr=%h wen=%b mask=%h want 1/80000000/0/00",
                             mem_req_valid, mem_addr, mem_wen, mem_wmask);
                end
            end
            n_cmp++;
            if (if_resp_valid !== (c == 3)) begin
                n_fail++;
                $display("FAIL if_latency: cycle %0d got if_resp_valid=%b want %b",
                         c, if_resp_valid, c == 3);
            end
        end
        wait_drain();
    endtask

    task automatic test_conflict();
        int   grants;
        int   n;
        logic exp_ls;
        do_reset();
        grants = 0; n = 0; exp_ls = 1'b0;
        if_addr = 32'h8000_0100;
        ls_addr = 32'h8000_2000; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        while (grants < 3 && n < 100) begin
            @(negedge clk);
            if (if_req_ready || ls_req_ready) begin
                n_cmp++;
                if (ls_req_ready !== exp_ls || if_req_ready !== !exp_ls) begin
                    n_fail++;
                    $display("FAIL conflict_grant %0d: got if=%b ls=%b want ls=%b",
                             grants, if_req_ready, ls_req_ready, exp_ls);
                end
                sb_q.push_back('{exp_ls, mem_model(exp_ls ? ls_addr : if_addr), 1'b0});
                exp_ls = !exp_ls;
                grants++;
            end
            tick();
            n++;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        n_cmp++;
        if (grants != 3) begin
            n_fail++;
            $display("FAIL conflict_count: got %0d grants want 3", grants);
        end
        wait_drain();
    endtask

    task automatic test_ls_write();
        req_delay = 4; resp_delay = 1;
        issue(1'b1, 32'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
            {1'b1, 32'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F}) begin
            n_fail++;
            $display("FAIL ls_mem_req: got v=%b addr=%h wen=%b data=%h mask=%h want 1/80001000/1/deadbeef/0f",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        wait_drain();
        req_delay = 0; resp_delay = 0;
    endtask

    task automatic test_timeout();
        int c;
        resp_en = 1'b0;
        issue(1'b1, 32'h8000_3000, 1'b0, '0, '0, 1'b1, 1'b1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!ls_resp_valid && c < 20);
        n_cmp++;
        if (c != 2 + TMO) begin
            n_fail++;
            $display("FAIL timeout_cycle: got pulse at cycle %0d want %0d", c, 2 + TMO);
        end
        @(negedge clk);
        n_cmp++;
        if ({timeout_err, ls_resp_valid, mem_req_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_pulse_len: got err=%b resp=%b req=%b want 000",
                     timeout_err, ls_resp_valid, mem_req_valid);
        end
        resp_en = 1'b1;
        wait_drain();
        // Arbiter is usable again after the forced response.
        issue(1'b0, 32'h8000_0000, 1'b0, '0, '0, 1'b1, 1'b0);
        wait_drain();
    endtask

    task automatic test_stray();
        stray_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_req_valid, if_resp_valid, ls_resp_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL stray_idle: got req=%b if=%b ls=%b want 000",
                         mem_req_valid, if_resp_valid, ls_resp_valid);
            end
        end
        tick();
        req_delay = 3;
        issue(1'b1, 32'h8000_4000, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_req_valid !== 1'b1 || ls_resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_req: got req=%b resp=%b want 1/0", mem_req_valid, ls_resp_valid);
            end
        end
        wait_drain();
        stray_en = 1'b0;
        req_delay = 0;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_conflict();
        test_ls_write();
        test_timeout();
        test_stray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
